// File: rtl/ex_mem_stage_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_reg
//
// EX/MEM pipeline register with valid/ready flow control. It holds a main
// entry (M), which drives the outputs, and one skid entry (S). Because of
// the skid entry, in_ready can come straight from a flop: when MEM stalls,
// the one result EX already launched lands in S instead of being lost.
// A synchronous flush clears both valid bits and leaves the data contents
// alone.
//
// Optional feature (macro STAGE_PERF_CNT_EN): adds saturating stall and
// bubble counters (stall_cnt, bubble_cnt) of width CNT_W.
//
// Parameters:
//   XLEN   width of pc / alu result / branch target / store data
//   REGW   width of destination register index
//   CNT_W  counter width (only with STAGE_PERF_CNT_EN)
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               squash all held entries at the next edge
//   in_valid/in_ready   EX-side handshake (in_ready is registered)
//   pcE..writeregE      execute-stage fields
//   out_valid/out_ready MEM-side handshake
//   pcM..writeregM      fields of the head entry
//   stall_cnt           cycles with out_valid & !out_ready (optional)
//   bubble_cnt          cycles with !out_valid (optional)
// ---------------------------------------------------------------------------
module ex_mem_stage_reg #(
  parameter int XLEN = 32,
  parameter int REGW = 5
`ifdef STAGE_PERF_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pcE,
  input  logic [XLEN-1:0] aluresultE,
  input  logic            zero_flagE,
  input  logic [XLEN-1:0] bj_targetE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [REGW-1:0] writeregE,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pcM,
  output logic [XLEN-1:0] aluoutM,
  output logic            zero_flagM,
  output logic [XLEN-1:0] bj_targetM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [REGW-1:0] writeregM
`ifdef STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  // All fields travel together as one packed entry.
  localparam int EW = 4 * XLEN + 1 + REGW;

  // State is just the pair of valid bits {s_valid, m_valid}. S is only
  // ever filled while M is valid, so 2'b10 cannot occur.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic          m_valid;
  logic          s_valid;
  logic          in_ready_q;
  logic [EW-1:0] m_data;
  logic [EW-1:0] s_data;
  logic [EW-1:0] in_data;
  logic [1:0]    state;
  logic          accept;
  logic          drain;

  assign state   = {s_valid, m_valid};
  assign in_data = {pcE, aluresultE, zero_flagE, bj_targetE, WriteDataE, writeregE};
  assign accept  = in_valid & in_ready_q;
  assign drain   = m_valid & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid;
  assign {pcM, aluoutM, zero_flagM, bj_targetM, WriteDataM, writeregM} = m_data;

  // Entry storage and flow control. in_ready_q is updated alongside the
  // valid bits so that it always equals "state is not FULL" and never
  // depends combinationally on out_ready. Flush wins over accept and drain
  // and only touches the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
      m_data     <= '0;
      s_data     <= '0;
    end else if (flush) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            m_data  <= in_data;
            m_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            m_data <= in_data;
          end else if (accept) begin
            // MEM is stalled: park the new entry in the skid slot and
            // stop EX for the following cycles.
            s_data     <= in_data;
            s_valid    <= 1'b1;
            in_ready_q <= 1'b0;
          end else if (drain) begin
            m_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can move things.
          if (drain) begin
            m_data     <= s_data;
            s_valid    <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding; fall back to EMPTY.
          m_valid    <= 1'b0;
          s_valid    <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef STAGE_PERF_CNT_EN
  // Saturating performance counters, sampled from the outputs as seen by
  // MEM. They are cleared only by reset and ignore flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (m_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (!m_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
Parametrised EX/MEM pipeline register for the multicycle/pipelined processor. It carries the execute-stage results to the memory stage: PC, ALU result, zero flag, branch/jump target, store data and destination register.
- Adds valid/ready flow control, a 2-entry skid buffer and a synchronous flush.
- Lets the memory stage stall, and lets hazard logic squash EX results, without a combinational ready path back into execute.

Parameters:
XLEN, 32, width of pc, alu_result, bj_target, write_data
REGW, 5, width of destination register index
CNT_W, 16, width of performance counters (only with STAGE_PERF_CNT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  EX stage presents a result
in_ready  out  1  register can accept; driven directly from a flop
pcE  in  XLEN  PC of instruction in EX
aluresultE  in  XLEN  ALU result
zero_flagE  in  1  ALU zero flag
bj_targetE  in  XLEN  branch/jump target (full width)
WriteDataE  in  XLEN  store data
writeregE  in  REGW  destination register
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM stage consumes entry
pcM, aluoutM, zero_flagM, bj_targetM, WriteDataM, writeregM  out  as inputs  registered fields of head entry

Behaviour:
- Storage: main entry M drives the outputs; skid entry S holds one extra entry. Each has a valid bit.
- State is {EMPTY, ONE, FULL}, encoded by the valid bits.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- in_ready = (state != FULL), registered. out_valid = M.valid.
- Transitions when flush = 0:
  - EMPTY: accept -> ONE, M <= inputs.
  - ONE: accept & drain -> ONE, M <= inputs.
  - ONE: accept & !drain -> FULL, S <= inputs.
  - ONE: !accept & drain -> EMPTY.
  - ONE: neither -> hold.
  - FULL: drain -> ONE, M <= S. No accept is possible because in_ready = 0.
  - FULL: no drain -> hold; outputs stable.
- Latency: 1 cycle from accept in EMPTY to out_valid.
- Throughput: 1 entry/cycle while out_ready = 1.
- Ordering: strictly FIFO; an entry is never duplicated or dropped except by flush.
- Outputs are stable while out_valid & !out_ready.
- Flush: next state EMPTY, in_ready = 1. Flush overrides both accept and drain.
  - The input presented during the flush cycle is discarded.
  - A drain in the flush cycle still counts as consumed.
  - Data fields keep their old contents; only the valid bits clear.
- Reset (rst_n low, asynchronous):
  - State EMPTY, out_valid = 0, in_ready = 1.
  - All data outputs = 0.
  - Reset mid-transfer discards both entries.
  - Deassertion takes effect on the next rising clk edge.
- Width rules: all fields are passed through unmodified. bj_target is full XLEN and is never truncated.

Optional Feature:
Macro STAGE_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt [CNT_W] and bubble_cnt [CNT_W].
  - stall_cnt increments on cycles with out_valid & !out_ready.
  - bubble_cnt increments on cycles with !out_valid.
  - Both counters saturate at all-ones, reset to 0 on rst_n, and are not affected by flush.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Streaming: rst_n released, out_ready = 1; accept pcE = 0x100, 0x104, 0x108 on back-to-back cycles -> pcM shows 0x100, 0x104, 0x108 one cycle after each accept; in_ready stays 1.
- Stall: with M holding aluresult 0xDEAD, hold out_ready = 0 and accept 0xBEEF -> in_ready = 0 next cycle and 0xDEAD stays stable. Release out_ready -> 0xDEAD drains, then 0xBEEF; in_ready returns to 1.
- Flush in FULL, with in_valid = 1 and new data 0x55 -> next cycle out_valid = 0, in_ready = 1; 0x55 is never output.
- Async reset: pull rst_n low mid-cycle while FULL -> out_valid = 0 and all data outputs = 0 immediately, without waiting for clk.
- Width: XLEN = 64, REGW = 6, bj_targetE = 0xFFFF_0000_1234_5678, writeregE = 63 -> identical values on bj_targetM and writeregM.
- STAGE_PERF_CNT_EN, CNT_W = 4: stall for 20 cycles -> stall_cnt = 15 (saturated); the first 3 idle cycles after reset give bubble_cnt = 3.
